// File: rtl/lms_ctr_oc_mem_arb.sv
// lms_ctr_oc_mem_arb: round-robin two-master arbiter for a single-port on-chip memory,
// with an optional post-reset zero-fill. Rev 1.0
`default_nettype none

module lms_ctr_oc_mem_arb #(
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 32,
  parameter int CLEAR_ON_RESET = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic                clear_done
);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_CLEAR = 2'd1,
    ST_ARB   = 2'd2
  } state_t;

  state_t              state, state_next;
  logic                rr_last;
  logic [1:0]          rd_pend;
  logic [ADDR_W-1:0]   clear_cnt;
  logic                clear_done_q;
  logic                req0, req1, grant0, grant1;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_RESET;
    else          state <= state_next;
  end

  always_comb begin
    state_next     = state;
    grant0         = 1'b0;
    grant1         = 1'b0;
    mem_address    = '0;
    mem_byteenable = '0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_writedata  = '0;
    case (state)
      ST_RESET: state_next = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_ARB;
      ST_CLEAR: begin
        mem_chipselect = 1'b1;
        mem_write      = 1'b1;
        mem_byteenable = '1;
        mem_address    = clear_cnt;
        if (clear_cnt == '1) state_next = ST_ARB;
      end
      ST_ARB: begin
        // On conflict the master that did not win last time is served.
        grant0 = req0 & (~req1 | rr_last);
        grant1 = req1 & (~req0 | ~rr_last);
        if (grant0) begin
          mem_address    = m0_address;
          mem_byteenable = m0_byteenable;
          mem_writedata  = m0_writedata;
          mem_write      = m0_write;
        end else if (grant1) begin
          mem_address    = m1_address;
          mem_byteenable = m1_byteenable;
          mem_writedata  = m1_writedata;
          mem_write      = m1_write;
        end
        mem_chipselect = grant0 | grant1;
      end
      default: state_next = ST_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_last      <= 1'b1;
      rd_pend      <= 2'b00;
      clear_cnt    <= '0;
      clear_done_q <= 1'b0;
    end else begin
      clear_done_q <= (state_next == ST_ARB);
      if (state == ST_CLEAR) clear_cnt <= clear_cnt + 1'b1;
      if (grant0)      rr_last <= 1'b0;
      else if (grant1) rr_last <= 1'b1;
      // A combined read+write is a write only, so it never returns data.
      rd_pend[0] <= grant0 & m0_read & ~m0_write;
      rd_pend[1] <= grant1 & m1_read & ~m1_write;
    end
  end

  assign m0_waitrequest   = ~grant0;
  assign m1_waitrequest   = ~grant1;
  assign m0_readdatavalid = rd_pend[0];
  assign m1_readdatavalid = rd_pend[1];
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign mem_clken        = 1'b1;
  assign clear_done       = clear_done_q;

endmodule

`default_nettype wire

// File: tb/tb_lms_ctr_oc_mem_arb.sv
// tb_lms_ctr_oc_mem_arb: directed bench for the memory arbiter, with a behavioural
// single-port RAM (registered address, unregistered q) behind each instance.
`default_nettype none

module tb_lms_ctr_oc_mem_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: no zero-fill
  logic        reset_n;
  logic [11:0] m0_address, m1_address, mem_address;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [3:0]  m0_byteenable, m1_byteenable, mem_byteenable;
  logic [31:0] m0_writedata, m1_writedata, m0_readdata, m1_readdata;
  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic        mem_chipselect, mem_write, mem_clken, clear_done;
  logic [31:0] mem_writedata, mem_readdata;

  // Instance B: zero-fill enabled
  logic        c_reset_n;
  logic [11:0] cm0_address, cm1_address, c_mem_address;
  logic        cm0_read, cm0_write, cm1_read, cm1_write;
  logic [3:0]  cm0_byteenable, cm1_byteenable, c_mem_byteenable;
  logic [31:0] cm0_writedata, cm1_writedata, cm0_readdata, cm1_readdata;
  logic        cm0_waitrequest, cm1_waitrequest, cm0_readdatavalid, cm1_readdatavalid;
  logic        c_mem_chipselect, c_mem_write, c_mem_clken, c_clear_done;
  logic [31:0] c_mem_writedata, c_mem_readdata;

  lms_ctr_oc_mem_arb #(.ADDR_W(12), .DATA_W(32), .CLEAR_ON_RESET(0)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .clear_done(clear_done)
  );

  lms_ctr_oc_mem_arb #(.ADDR_W(12), .DATA_W(32), .CLEAR_ON_RESET(1)) dut_clr (
    .clk(clk), .reset_n(c_reset_n),
    .m0_address(cm0_address), .m0_read(cm0_read), .m0_write(cm0_write),
    .m0_byteenable(cm0_byteenable), .m0_writedata(cm0_writedata),
    .m0_waitrequest(cm0_waitrequest), .m0_readdata(cm0_readdata),
    .m0_readdatavalid(cm0_readdatavalid),
    .m1_address(cm1_address), .m1_read(cm1_read), .m1_write(cm1_write),
    .m1_byteenable(cm1_byteenable), .m1_writedata(cm1_writedata),
    .m1_waitrequest(cm1_waitrequest), .m1_readdata(cm1_readdata),
    .m1_readdatavalid(cm1_readdatavalid),
    .mem_address(c_mem_address), .mem_byteenable(c_mem_byteenable),
    .mem_chipselect(c_mem_chipselect), .mem_write(c_mem_write),
    .mem_writedata(c_mem_writedata), .mem_clken(c_mem_clken),
    .mem_readdata(c_mem_readdata), .clear_done(c_clear_done)
  );

  // Behavioural RAMs; B starts with a non-zero pattern so the fill is visible.
  logic [31:0] ram_a [0:4095];
  logic [31:0] ram_b [0:4095];
  logic [11:0] aq_a, aq_b;

  initial begin
    for (int k = 0; k < 4096; k++) begin
      ram_a[k] = 32'h0;
      ram_b[k] = 32'hA5A5_A5A5;
    end
    aq_a = '0;
    aq_b = '0;
  end

  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      aq_a <= mem_address;
      if (mem_write)
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram_a[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
    end
  end

  always @(posedge clk) begin
    if (c_mem_chipselect && c_mem_clken) begin
      aq_b <= c_mem_address;
      if (c_mem_write)
        for (int b = 0; b < 4; b++)
          if (c_mem_byteenable[b]) ram_b[c_mem_address][8*b +: 8] <= c_mem_writedata[8*b +: 8];
    end
  end

  assign mem_readdata   = ram_a[aq_a];
  assign c_mem_readdata = ram_b[aq_b];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  initial begin
    int bad;
    reset_n = 1'b0;  c_reset_n = 1'b0;
    m0_address = 12'h000; m0_read = 1'b1; m0_write = 1'b0; m0_byteenable = 4'hF; m0_writedata = '0;
    m1_address = 12'h000; m1_read = 1'b0; m1_write = 1'b0; m1_byteenable = 4'hF; m1_writedata = '0;
    cm0_address = 12'h000; cm0_read = 1'b1; cm0_write = 1'b0; cm0_byteenable = 4'hF; cm0_writedata = '0;
    cm1_address = 12'h000; cm1_read = 1'b0; cm1_write = 1'b0; cm1_byteenable = 4'hF; cm1_writedata = '0;

    // 1: reset outputs, then release with m0_read held
    tick; tick; #1;
    check("rst_m0_wait", m0_waitrequest, 1);
    check("rst_m1_wait", m1_waitrequest, 1);
    check("rst_m0_rdv", m0_readdatavalid, 0);
    check("rst_cs", mem_chipselect, 0);
    check("rst_we", mem_write, 0);
    check("rst_clear_done", clear_done, 0);
    reset_n = 1'b1; #1;
    check("pre_edge_m0_wait", m0_waitrequest, 1);
    tick; #1;
    check("first_m0_wait", m0_waitrequest, 0);
    check("first_clear_done", clear_done, 1);
    check("first_cs", mem_chipselect, 1);

    // 2: m0 writes 0x010, m1 reads it back
    tick;
    m0_read = 1'b0; m0_write = 1'b1; m0_address = 12'h010; m0_writedata = 32'hDEAD_BEEF; #1;
    check("boot_read_rdv", m0_readdatavalid, 1);
    check("boot_read_data", m0_readdata, 32'h0);
    check("wr_m0_wait", m0_waitrequest, 0);
    check("wr_mem_we", mem_write, 1);
    check("wr_mem_addr", mem_address, 32'h010);
    check("wr_mem_data", mem_writedata, 32'hDEAD_BEEF);
    tick;
    m0_write = 1'b0; m1_read = 1'b1; m1_address = 12'h010; #1;
    check("rd_m1_wait", m1_waitrequest, 0);
    check("rd_mem_we", mem_write, 0);
    check("rd_mem_addr", mem_address, 32'h010);
    tick;
    m1_read = 1'b0; #1;
    check("rd_m1_rdv", m1_readdatavalid, 1);
    check("rd_m1_data", m1_readdata, 32'hDEAD_BEEF);
    check("rd_m0_rdv", m0_readdatavalid, 0);
    tick; #1;
    check("rd_m1_rdv_single", m1_readdatavalid, 0);

    // 3: both request continuously -> m0,m1,m0,m1
    m0_read = 1'b1; m1_read = 1'b1; m0_address = 12'h010; m1_address = 12'h010; #1;
    for (int i = 0; i < 4; i++) begin
      check("rr_m0_wait", m0_waitrequest, (i % 2 == 1));
      check("rr_m1_wait", m1_waitrequest, (i % 2 == 0));
      check("rr_m0_rdv", m0_readdatavalid, (i % 2 == 1));
      check("rr_m1_rdv", m1_readdatavalid, (i > 0) && (i % 2 == 0));
      tick; #1;
    end
    m0_read = 1'b0; m1_read = 1'b0; #1;
    check("rr_tail_m1_rdv", m1_readdatavalid, 1);
    check("rr_tail_m0_rdv", m0_readdatavalid, 0);
    check("rr_tail_data", m1_readdata, 32'hDEAD_BEEF);

    // 4: byte-lane merge, write->read same address, write during read return
    tick;
    m0_write = 1'b1; m0_address = 12'h3FF; m0_writedata = 32'h1234_5678; m0_byteenable = 4'hF; #1;
    check("be_wr1_wait", m0_waitrequest, 0);
    tick;
    m0_writedata = 32'h0000_AAAA; m0_byteenable = 4'b0011; #1;
    check("be_wr2_be", mem_byteenable, 32'h3);
    tick;
    m0_write = 1'b0; m0_read = 1'b1; m0_byteenable = 4'hF; #1;
    check("be_rd_we", mem_write, 0);
    tick;
    m0_read = 1'b0; m1_write = 1'b1; m1_address = 12'h3FF; m1_writedata = 32'hFFFF_FFFF; #1;
    check("be_rd_rdv", m0_readdatavalid, 1);
    check("be_rd_data", m0_readdata, 32'h1234_AAAA);
    check("wr_after_rd_wait", m1_waitrequest, 0);
    tick;
    m1_write = 1'b0; m1_read = 1'b1; #1;
    check("wr_after_rd_no_rdv", m0_readdatavalid, 0);
    tick;
    m1_read = 1'b0; #1;
    check("wr_after_rd_rdv", m1_readdatavalid, 1);
    check("wr_after_rd_data", m1_readdata, 32'hFFFF_FFFF);

    // read and write together act as a write
    tick;
    m0_read = 1'b1; m0_write = 1'b1; m0_address = 12'h020; m0_writedata = 32'h0000_0055; #1;
    check("rw_mem_we", mem_write, 1);
    tick;
    m0_write = 1'b0; #1;
    check("rw_no_rdv", m0_readdatavalid, 0);
    tick;
    m0_read = 1'b0; #1;
    check("rw_readback_rdv", m0_readdatavalid, 1);
    check("rw_readback_data", m0_readdata, 32'h0000_0055);

    // 6: reset right after a read accept
    tick;
    m1_read = 1'b1; m1_address = 12'h010; #1;
    check("rr6_m1_wait", m1_waitrequest, 0);
    @(posedge clk); #1;
    reset_n = 1'b0; m1_read = 1'b0;
    tick; #1;
    check("rr6_rdv_killed", m1_readdatavalid, 0);
    check("rr6_wait_in_rst", m1_waitrequest, 1);
    tick; tick;
    reset_n = 1'b1; m1_read = 1'b1; #1;
    check("rr6_wait_pre_edge", m1_waitrequest, 1);
    tick; #1;
    check("rr6_regrant", m1_waitrequest, 0);
    tick;
    m1_read = 1'b0; #1;
    check("rr6_rdv", m1_readdatavalid, 1);
    check("rr6_data", m1_readdata, 32'hDEAD_BEEF);

    // 5: zero-fill instance
    #1;
    check("clr_rst_done", c_clear_done, 0);
    check("clr_rst_wait", cm0_waitrequest, 1);
    check("clr_rst_cs", c_mem_chipselect, 0);
    tick;
    c_reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 4096; i++) begin
      tick; #1;
      if (c_mem_address !== 12'(i) || c_mem_chipselect !== 1'b1 || c_mem_write !== 1'b1 ||
          c_mem_byteenable !== 4'hF || c_mem_writedata !== 32'h0 ||
          cm0_waitrequest !== 1'b1 || cm1_waitrequest !== 1'b1 || c_clear_done !== 1'b0)
        bad++;
    end
    check("clr_sequence_bad_cycles", bad, 0);
    tick; #1;
    check("clr_done", c_clear_done, 1);
    check("clr_m0_wait", cm0_waitrequest, 0);
    tick;
    cm0_read = 1'b0; cm1_read = 1'b1; cm1_address = 12'hFFF; #1;
    check("clr_rd0_rdv", cm0_readdatavalid, 1);
    check("clr_rd0_data", cm0_readdata, 32'h0);
    tick;
    cm1_read = 1'b0; #1;
    check("clr_rdfff_rdv", cm1_readdatavalid, 1);
    check("clr_rdfff_data", cm1_readdata, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
